// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops burst_len words from a synchronous FIFO and streams them out on valid/ready.
// Optional build macro: FIFO_BURST_READER_STATS_EN (adds stat_words / stat_starve counters).
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   start, burst_len      - burst request and its length (sampled when idle)
//   fifo_empty, fifo_data - FIFO status and read data (data valid one cycle after fifo_rd_en)
//   fifo_rd_en            - FIFO read enable (combinational)
//   m_valid, m_ready      - downstream handshake
//   m_data, m_last        - downstream word and end-of-burst marker
//   busy, done            - burst in progress / one-cycle completion pulse
//   stat_words, stat_starve (macro only) - accepted-word and FIFO-starvation counters
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      burst_len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
`ifdef FIFO_BURST_READER_STATS_EN
    output logic                  done,
    output logic [31:0]           stat_words,
    output logic [15:0]           stat_starve
`else
    output logic                  done
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [CNT_W-1:0]      rem_issue;
    logic [CNT_W-1:0]      rem_out;
    logic                  inflight;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] sb0;
    logic [DATA_WIDTH-1:0] sb1;
    logic                  pop;
    logic [1:0]            wr_idx;
    logic [DATA_WIDTH-1:0] nx0;
    logic [DATA_WIDTH-1:0] nx1;

    assign pop     = m_valid & m_ready;
    assign m_valid = occ != 2'd0;
    assign m_data  = sb0;
    assign m_last  = m_valid && rem_out == CNT_W'(1);
    // Only issue a read if the buffer is guaranteed a free slot when the word lands next cycle.
    assign fifo_rd_en = state == RUN && !fifo_empty && rem_issue != '0 &&
                        ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;

    // Head is sb0; a pop shifts sb1 forward, and the landing word goes to the first free slot after that.
    always_comb begin
        wr_idx = occ - {1'b0, pop};
        nx0    = (inflight && wr_idx == 2'd0) ? fifo_data : pop ? sb1 : sb0;
        nx1    = (inflight && wr_idx == 2'd1) ? fifo_data : sb1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rem_issue <= '0;
            rem_out   <= '0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            sb0       <= '0;
            sb1       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= fifo_rd_en;
            occ      <= occ - {1'b0, pop} + {1'b0, inflight};
            sb0      <= nx0;
            sb1      <= nx1;
            if (fifo_rd_en)
                rem_issue <= rem_issue - CNT_W'(1);
            if (pop)
                rem_out <= rem_out - CNT_W'(1);
            case (state)
                IDLE: begin
                    if (start && burst_len != '0) begin
                        state     <= RUN;
                        rem_issue <= burst_len;
                        rem_out   <= burst_len;
                        busy      <= 1'b1;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    if (fifo_rd_en && rem_issue == CNT_W'(1))
                        state <= DRAIN;
                end
                default: ;
            endcase
            if (state != IDLE && pop && rem_out == CNT_W'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_words  <= '0;
            stat_starve <= '0;
        end else begin
            if (pop && stat_words != '1)
                stat_words <= stat_words + 32'd1;
            if (state == RUN && rem_issue != '0 && fifo_empty && stat_starve != '1)
                stat_starve <= stat_starve + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scoreboard bench with a behavioural FIFO and a burst reference model.
module tb_fifo_burst_reader;
    localparam int DW = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          m_ready = 1'b0;
    logic          fifo_rd_en, m_valid, m_last, busy, done;
    logic [DW-1:0] m_data;
`ifdef FIFO_BURST_READER_STATS_EN
    logic [31:0]   stat_words;
    logic [15:0]   stat_starve;
`endif

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy),
`ifdef FIFO_BURST_READER_STATS_EN
        .done(done), .stat_words(stat_words), .stat_starve(stat_starve)
`else
        .done(done)
`endif
    );

    // Behavioural FIFO: every word ever written is also logged in content, in write order.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] content[$];
    int push_total = 0;
    int pushed = 0;
    always @(posedge clk) begin
        if (reset)
            fq.delete();
        else if (fifo_rd_en && fq.size() > 0)
            fifo_data <= fq.pop_front();
        while (pushed < push_total) begin
            content.push_back(DW'($urandom));
            fq.push_back(content[content.size()-1]);
            pushed++;
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Consumer: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
    int ready_mode = 0;
    int ph = 0;
    always @(posedge clk) begin
        #1;
        m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (ph == 0) : 1'($urandom % 2);
        ph = (ph + 1) % 3;
    end

    typedef struct {
        int idx;
        bit last;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int acc_total = 0;
    int timeouts = 0;
    bit finish_req = 0;
    bit lat_req = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: all comparisons happen here, sampled on the falling edge.
    bit rst_prev = 0, done_due = 0, stall_prev = 0, tracking = 0;
    logic [DW-1:0] pd;
    bit pl;
    int since = 0, rd_cnt = 0, rd_exp = 0;
    exp_t e;
    always @(negedge clk) begin
        if (finish_req) begin
            chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
            chk(timeouts == 0, "timeouts", timeouts, 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
        if (reset) begin
            exp_q.delete();
            done_due = 0;
            stall_prev = 0;
            tracking = 0;
            rst_prev = 1;
        end else begin
            if (rst_prev)
                chk({fifo_rd_en, m_valid, m_last, busy, done, m_data} == '0, "reset_state",
                    {fifo_rd_en, m_valid, m_last, busy, done, m_data}, 0);
            rst_prev = 0;
            chk(!fifo_rd_en || (busy && !fifo_empty), "rd_gate", {fifo_rd_en, busy, fifo_empty}, 0);
            if (stall_prev)
                chk(m_valid && m_data == pd && m_last == pl, "stall_hold",
                    {m_valid, m_last, m_data}, {1'b1, pl, pd});
            chk(done == done_due, "done", done, done_due);
            if (done) begin
                chk(!busy, "busy_at_done", busy, 0);
                chk(rd_cnt == rd_exp, "read_count", rd_cnt, rd_exp);
            end
            if (tracking) begin
                since++;
                if (since == 1)
                    chk(busy && fifo_rd_en, "first_issue", {busy, fifo_rd_en}, 2'b11);
                if (since < 3)
                    chk(!m_valid, "latency_early", m_valid, 0);
                else if (exp_q.size() > 0)
                    chk(m_valid, "latency_or_gap", m_valid, 1);
            end
            done_due = 0;
            if (fifo_rd_en)
                rd_cnt++;
            if (m_valid && m_ready) begin
                acc_total++;
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_word", m_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(m_data == content[e.idx], "data", m_data, content[e.idx]);
                    chk(m_last == e.last, "last", m_last, e.last);
                    if (e.last) begin
                        done_due = 1;
                        tracking = 0;
                    end
                end
            end
            if (start && !busy) begin
                rd_cnt = 0;
                rd_exp = burst_len;
                if (burst_len == 0)
                    done_due = 1;
                else if (lat_req) begin
                    tracking = 1;
                    since = 0;
                end
            end
            stall_prev = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
        end
    end

    // Stimulus
    int base = 0;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeouts++;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeouts++;
    endtask

    task automatic start_burst(input int len, input bit lat);
        exp_t x;
        wait_idle();
        lat_req = lat;
        start = 1'b1;
        burst_len = CW'(len);
        for (int i = 0; i < len; i++) begin
            x.idx = base + i;
            x.last = (i == len - 1);
            exp_q.push_back(x);
        end
        base += len;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int a0, n, rem, k, len;
        // Reset then idle with a non-empty FIFO and no start.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        push_total += 16;
        tick(4);
        // Full-rate burst with latency and continuity tracking.
        ready_mode = 0;
        start_burst(16, 1);
        wait_done();
        // Backpressure.
        ready_mode = 1;
        push_total += 8;
        tick(2);
        start_burst(8, 0);
        wait_done();
        // Starvation: half the words arrive ten cycles late.
        ready_mode = 0;
        push_total += 3;
        tick(2);
        start_burst(6, 0);
        tick(10);
        push_total += 3;
        wait_done();
        // Edge lengths.
        start_burst(0, 0);
        wait_done();
        push_total += 1;
        tick(2);
        start_burst(1, 0);
        wait_done();
        // Start while busy must not disturb the running burst.
        ready_mode = 2;
        push_total += 8;
        tick(2);
        start_burst(8, 0);
        tick(3);
        start = 1'b1;
        burst_len = CW'(5);
        tick();
        start = 1'b0;
        wait_done();
        // Reset after four accepted words.
        ready_mode = 0;
        push_total += 10;
        tick(2);
        a0 = acc_total;
        start_burst(10, 0);
        n = 0;
        while (acc_total < a0 + 4 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeouts++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(4);
        base = content.size();
        // Random bursts with dripping FIFO supply.
        for (int r = 0; r < 30; r++) begin
            ready_mode = $urandom % 3;
            len = $urandom % 32;
            k = $urandom_range(0, len);
            push_total += k;
            rem = len - k;
            tick(2);
            start_burst(len, 0);
            while (rem > 0) begin
                tick($urandom_range(0, 5));
                k = $urandom_range(1, rem);
                push_total += k;
                rem -= k;
            end
            wait_done();
        end
        tick(4);
        finish_req = 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
